// File: rtl/csi_capture_controller.sv
// Frame capture sequencer for a CSI-2 packet receiver: arms on request, gates one VC's video words out.
// Latency 1 cycle from payload word to out_valid; no backpressure, the receiver stream cannot be stalled.
module csi_capture_controller #(
   parameter logic [1:0] VC        = 2'b00,
   parameter logic [5:0] VIDEO_DT  = 6'h2B,
   parameter int         LINE_W    = 12,
   parameter int         TIMEOUT_W = 20
) (
   input  logic              clock_p,
   input  logic              reset,
   input  logic              arm,
   input  logic              abort,
   input  logic              continuous,
   input  logic [7:0]        frames_requested,
   input  logic [LINE_W-1:0] expected_lines,
   input  logic              interrupt,
   input  logic              image_data_enable,
   input  logic [5:0]        image_data_type,
   input  logic [1:0]        virtual_channel,
   input  logic [15:0]       word_count,
   input  logic [31:0]       image_data,
   output logic [31:0]       out_data,
   output logic              out_valid,
   output logic              out_sof,
   output logic              out_eol,
   output logic              busy,
   output logic              done,
   output logic [LINE_W-1:0] line_count,
   output logic [7:0]        frame_count,
   output logic              err_line_length,
   output logic              err_line_count,
   output logic              err_timeout
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ARMED = 2'd1,
      S_FRAME = 2'd2
   } state_t;

   state_t              state;
   logic                cont_r;
   logic [7:0]          frames_req_r;
   logic [LINE_W-1:0]   exp_lines_r;
   logic [13:0]         word_ctr;
   logic [13:0]         target_r;
   logic                sof_pending;
   logic [TIMEOUT_W-1:0] tmo_ctr;

   logic                vc_hit;
   logic                sp;
   logic                ev_fs;
   logic                ev_fe;
   logic                ev_pw;
   logic [13:0]         wc_words;
   logic [13:0]         cur_target;
   logic                line_end;
   logic                len_bad;
   logic                cnt_bad;
   logic                last_frame;
   logic                tmo_hit;
   logic [7:0]          frame_inc;
   logic [LINE_W-1:0]   line_inc;

   assign vc_hit = (virtual_channel == VC);
   assign sp     = interrupt & ~image_data_enable & vc_hit;
   assign ev_fs  = sp & (image_data_type == 6'h00);
   assign ev_fe  = sp & (image_data_type == 6'h01);
   assign ev_pw  = image_data_enable & vc_hit & (image_data_type == VIDEO_DT);

   // The line length is taken from the packet header seen with the first word of each line.
   assign wc_words   = word_count[15:2];
   assign cur_target = (word_ctr == 14'd0) ? ((wc_words == 14'd0) ? 14'd1 : wc_words) : target_r;
   assign line_end   = ((word_ctr + 14'd1) == cur_target);

   assign len_bad    = (word_ctr != 14'd0);
   assign cnt_bad    = (line_count != exp_lines_r);
   assign last_frame = !cont_r && (({1'b0, frame_count} + 9'd1) >= {1'b0, frames_req_r});
   assign tmo_hit    = &tmo_ctr;

   // Counters saturate so a long continuous run never wraps back to small values.
   assign frame_inc = (frame_count == 8'hFF) ? frame_count : frame_count + 8'd1;
   assign line_inc  = (&line_count) ? line_count : line_count + {{(LINE_W-1){1'b0}}, 1'b1};

   assign busy = (state != S_IDLE);

   always_ff @(posedge clock_p) begin
      if (reset) begin
         state           <= S_IDLE;
         cont_r          <= 1'b0;
         frames_req_r    <= 8'd0;
         exp_lines_r     <= '0;
         word_ctr        <= 14'd0;
         target_r        <= 14'd0;
         sof_pending     <= 1'b0;
         tmo_ctr         <= '0;
         out_data        <= 32'd0;
         out_valid       <= 1'b0;
         out_sof         <= 1'b0;
         out_eol         <= 1'b0;
         done            <= 1'b0;
         line_count      <= '0;
         frame_count     <= 8'd0;
         err_line_length <= 1'b0;
         err_line_count  <= 1'b0;
         err_timeout     <= 1'b0;
      end else begin
         out_data  <= 32'd0;
         out_valid <= 1'b0;
         out_sof   <= 1'b0;
         out_eol   <= 1'b0;
         done      <= 1'b0;

         if (state == S_IDLE || ev_fs || ev_fe || ev_pw) begin
            tmo_ctr <= '0;
         end else begin
            tmo_ctr <= tmo_ctr + {{(TIMEOUT_W-1){1'b0}}, 1'b1};
         end

         if (state != S_IDLE && abort) begin
            state <= S_IDLE;
            done  <= 1'b1;
         end else if (state != S_IDLE && tmo_hit) begin
            state       <= S_IDLE;
            done        <= 1'b1;
            err_timeout <= 1'b1;
         end else begin
            case (state)
               S_IDLE: begin
                  if (arm) begin
                     state           <= S_ARMED;
                     cont_r          <= continuous;
                     frames_req_r    <= (frames_requested == 8'd0) ? 8'd1 : frames_requested;
                     exp_lines_r     <= expected_lines;
                     word_ctr        <= 14'd0;
                     target_r        <= 14'd0;
                     sof_pending     <= 1'b0;
                     line_count      <= '0;
                     frame_count     <= 8'd0;
                     err_line_length <= 1'b0;
                     err_line_count  <= 1'b0;
                     err_timeout     <= 1'b0;
                  end
               end

               S_ARMED: begin
                  if (ev_fs) begin
                     state       <= S_FRAME;
                     sof_pending <= 1'b1;
                     word_ctr    <= 14'd0;
                     line_count  <= '0;
                  end
               end

               S_FRAME: begin
                  if (ev_pw) begin
                     target_r    <= cur_target;
                     out_valid   <= 1'b1;
                     out_data    <= image_data;
                     out_sof     <= sof_pending;
                     sof_pending <= 1'b0;
                     if (line_end) begin
                        out_eol    <= 1'b1;
                        word_ctr   <= 14'd0;
                        line_count <= line_inc;
                     end else begin
                        word_ctr <= word_ctr + 14'd1;
                     end
                  end else if (ev_fs || ev_fe) begin
                     // A Frame Start inside a frame closes the current frame, then opens the next.
                     if (len_bad) err_line_length <= 1'b1;
                     if (cnt_bad) err_line_count  <= 1'b1;
                     frame_count <= frame_inc;
                     word_ctr    <= 14'd0;
                     if (last_frame) begin
                        state <= S_IDLE;
                        done  <= 1'b1;
                     end else if (ev_fs) begin
                        line_count  <= '0;
                        sof_pending <= 1'b1;
                     end else begin
                        state <= S_ARMED;
                     end
                  end
               end

               default: state <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_csi_capture_controller.sv
// Directed bench for csi_capture_controller; timeout shortened to 8 bits to keep runs short.
module tb_csi_capture_controller;

   localparam int LINE_W    = 12;
   localparam int TIMEOUT_W = 8;
   localparam logic [5:0] DT = 6'h2B;

   logic              clock_p = 1'b0;
   logic              reset = 1'b1;
   logic              arm = 1'b0;
   logic              abort = 1'b0;
   logic              continuous = 1'b0;
   logic [7:0]        frames_requested = 8'd0;
   logic [LINE_W-1:0] expected_lines = '0;
   logic              interrupt = 1'b0;
   logic              image_data_enable = 1'b0;
   logic [5:0]        image_data_type = 6'd0;
   logic [1:0]        virtual_channel = 2'd0;
   logic [15:0]       word_count = 16'd0;
   logic [31:0]       image_data = 32'd0;
   logic [31:0]       out_data;
   logic              out_valid;
   logic              out_sof;
   logic              out_eol;
   logic              busy;
   logic              done;
   logic [LINE_W-1:0] line_count;
   logic [7:0]        frame_count;
   logic              err_line_length;
   logic              err_line_count;
   logic              err_timeout;

   int errors = 0;
   int checks = 0;

   logic [31:0] cap_data[$];
   logic        cap_sof[$];
   logic        cap_eol[$];
   int          done_cnt = 0;
   int          bad_idle = 0;

   csi_capture_controller #(.TIMEOUT_W(TIMEOUT_W)) dut (
      .clock_p(clock_p), .reset(reset), .arm(arm), .abort(abort),
      .continuous(continuous), .frames_requested(frames_requested),
      .expected_lines(expected_lines), .interrupt(interrupt),
      .image_data_enable(image_data_enable), .image_data_type(image_data_type),
      .virtual_channel(virtual_channel), .word_count(word_count),
      .image_data(image_data), .out_data(out_data), .out_valid(out_valid),
      .out_sof(out_sof), .out_eol(out_eol), .busy(busy), .done(done),
      .line_count(line_count), .frame_count(frame_count),
      .err_line_length(err_line_length), .err_line_count(err_line_count),
      .err_timeout(err_timeout)
   );

   always #5 clock_p = ~clock_p;

   always @(negedge clock_p) begin
      if (out_valid === 1'b1) begin
         cap_data.push_back(out_data);
         cap_sof.push_back(out_sof);
         cap_eol.push_back(out_eol);
      end else if (out_data !== 32'd0 || out_sof !== 1'b0 || out_eol !== 1'b0) begin
         bad_idle++;
      end
      if (done === 1'b1) done_cnt++;
   end

   task automatic tick();
      @(posedge clock_p);
      #1;
   endtask

   task automatic clear_cap();
      cap_data.delete();
      cap_sof.delete();
      cap_eol.delete();
      done_cnt = 0;
   endtask

   task automatic do_arm(input logic c, input logic [7:0] f, input logic [LINE_W-1:0] l);
      arm = 1'b1; continuous = c; frames_requested = f; expected_lines = l;
      tick();
      arm = 1'b0; continuous = 1'b0; frames_requested = 8'd0; expected_lines = '0;
   endtask

   task automatic short_pkt(input logic [1:0] vc, input logic [5:0] dt);
      interrupt = 1'b1; image_data_enable = 1'b0; virtual_channel = vc; image_data_type = dt;
      tick();
      interrupt = 1'b0; virtual_channel = 2'd0; image_data_type = 6'd0;
   endtask

   task automatic pw(input logic [1:0] vc, input logic [5:0] dt, input logic [15:0] wc,
                     input logic [31:0] d);
      interrupt = 1'b1; image_data_enable = 1'b1; virtual_channel = vc;
      image_data_type = dt; word_count = wc; image_data = d;
      tick();
      interrupt = 1'b0; image_data_enable = 1'b0; virtual_channel = 2'd0;
      image_data_type = 6'd0; word_count = 16'd0; image_data = 32'd0;
   endtask

   function automatic logic [3:0] flags4(input int which);
      logic [3:0] v = 4'b0;
      for (int i = 0; i < 4 && i < cap_sof.size(); i++) v[i] = (which == 0) ? cap_sof[i] : cap_eol[i];
      return v;
   endfunction

   task automatic test_reset();
      reset = 1'b1;
      tick(); tick();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b want 0", busy); end
      checks++; if ({out_valid, out_sof, out_eol, done} !== 4'b0) begin errors++; $display("FAIL reset_flags: got %b want 0000", {out_valid, out_sof, out_eol, done}); end
      checks++; if (out_data !== 32'd0) begin errors++; $display("FAIL reset_data: got %h want 0", out_data); end
      checks++; if (line_count !== '0 || frame_count !== 8'd0) begin errors++; $display("FAIL reset_counts: got %0d/%0d want 0/0", line_count, frame_count); end
      checks++; if ({err_line_length, err_line_count, err_timeout} !== 3'b0) begin errors++; $display("FAIL reset_errs: got %b want 000", {err_line_length, err_line_count, err_timeout}); end
      reset = 1'b0;
      tick();
   endtask

   task automatic test_single_frame();
      clear_cap();
      do_arm(1'b0, 8'd1, 12'd2);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %0b want 1", busy); end
      short_pkt(2'd0, 6'h00);
      for (int i = 0; i < 4; i++) pw(2'd0, DT, 16'd8, 32'hA0 + i);
      short_pkt(2'd0, 6'h01);
      tick();
      checks++; if (cap_data.size() != 4) begin errors++; $display("FAIL single_words: got %0d want 4", cap_data.size()); end
      checks++; if (cap_data.size() == 4 && (cap_data[0] !== 32'hA0 || cap_data[3] !== 32'hA3)) begin errors++; $display("FAIL single_data: got %h,%h want a0,a3", cap_data[0], cap_data[3]); end
      checks++; if (flags4(0) !== 4'b0001) begin errors++; $display("FAIL single_sof: got %b want 0001", flags4(0)); end
      checks++; if (flags4(1) !== 4'b1010) begin errors++; $display("FAIL single_eol: got %b want 1010", flags4(1)); end
      checks++; if (line_count !== 12'd2 || frame_count !== 8'd1) begin errors++; $display("FAIL single_counts: got %0d/%0d want 2/1", line_count, frame_count); end
      checks++; if (done_cnt != 1 || busy !== 1'b0) begin errors++; $display("FAIL single_done: got done=%0d busy=%0b want 1/0", done_cnt, busy); end
      checks++; if ({err_line_length, err_line_count, err_timeout} !== 3'b0) begin errors++; $display("FAIL single_errs: got %b want 000", {err_line_length, err_line_count, err_timeout}); end
   endtask

   task automatic test_frame_errors();
      do_arm(1'b0, 8'd1, 12'd2);
      short_pkt(2'd0, 6'h00);
      pw(2'd0, DT, 16'd8, 32'h1); pw(2'd0, DT, 16'd8, 32'h2);
      short_pkt(2'd0, 6'h01);
      tick();
      checks++; if ({err_line_length, err_line_count} !== 2'b01) begin errors++; $display("FAIL short_frame_errs: got %b want 01", {err_line_length, err_line_count}); end
      do_arm(1'b0, 8'd1, 12'd2);
      checks++; if (err_line_count !== 1'b0) begin errors++; $display("FAIL arm_clears_err: got %0b want 0", err_line_count); end
      short_pkt(2'd0, 6'h00);
      pw(2'd0, DT, 16'd8, 32'h1); pw(2'd0, DT, 16'd8, 32'h2); pw(2'd0, DT, 16'd8, 32'h3);
      short_pkt(2'd0, 6'h01);
      tick();
      checks++; if ({err_line_length, err_line_count} !== 2'b11) begin errors++; $display("FAIL mid_line_errs: got %b want 11", {err_line_length, err_line_count}); end
   endtask

   task automatic test_filter();
      clear_cap();
      short_pkt(2'd0, 6'h00);
      tick();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL fs_before_arm: got busy=%0b want 0", busy); end
      do_arm(1'b0, 8'd1, 12'd1);
      short_pkt(2'd0, 6'h00);
      pw(2'd1, DT, 16'd4, 32'hBAD1);
      pw(2'd0, 6'h2A, 16'd4, 32'hBAD2);
      short_pkt(2'd1, 6'h01);
      tick();
      checks++; if (cap_data.size() != 0 || busy !== 1'b1) begin errors++; $display("FAIL filter_ignored: got words=%0d busy=%0b want 0/1", cap_data.size(), busy); end
      pw(2'd0, DT, 16'd4, 32'hC0DE);
      short_pkt(2'd0, 6'h01);
      tick();
      checks++; if (cap_data.size() != 1 || flags4(0) !== 4'b0001 || flags4(1) !== 4'b0001) begin errors++; $display("FAIL filter_one_word: got n=%0d sof=%b eol=%b want 1/0001/0001", cap_data.size(), flags4(0), flags4(1)); end
      checks++; if (done_cnt != 1 || {err_line_length, err_line_count} !== 2'b00) begin errors++; $display("FAIL filter_done: got done=%0d errs=%b want 1/00", done_cnt, {err_line_length, err_line_count}); end
   endtask

   task automatic test_continuous_abort();
      clear_cap();
      do_arm(1'b1, 8'd1, 12'd1);
      for (int f = 0; f < 3; f++) begin
         short_pkt(2'd0, 6'h00);
         pw(2'd0, DT, 16'd4, 32'h100 + f);
         short_pkt(2'd0, 6'h01);
      end
      checks++; if (busy !== 1'b1 || frame_count !== 8'd3 || done_cnt != 0) begin errors++; $display("FAIL cont_running: got busy=%0b fc=%0d done=%0d want 1/3/0", busy, frame_count, done_cnt); end
      short_pkt(2'd0, 6'h00);
      pw(2'd0, DT, 16'd8, 32'h200);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL abort_done: got done=%0b busy=%0b want 1/0", done, busy); end
      checks++; if (frame_count !== 8'd3) begin errors++; $display("FAIL abort_frames: got %0d want 3", frame_count); end
      tick();
      checks++; if (done !== 1'b0 || done_cnt != 1) begin errors++; $display("FAIL abort_pulse: got done=%0b count=%0d want 0/1", done, done_cnt); end
      checks++; if (cap_data.size() != 4 || cap_data[cap_data.size()-1] !== 32'h200) begin errors++; $display("FAIL abort_inflight: got n=%0d want 4 ending 200", cap_data.size()); end
   endtask

   task automatic test_back_to_back();
      clear_cap();
      do_arm(1'b0, 8'd2, 12'd1);
      short_pkt(2'd0, 6'h00);
      pw(2'd0, DT, 16'd4, 32'h300);
      short_pkt(2'd0, 6'h00);
      checks++; if (busy !== 1'b1 || frame_count !== 8'd1 || line_count !== 12'd0) begin errors++; $display("FAIL b2b_mid: got busy=%0b fc=%0d lc=%0d want 1/1/0", busy, frame_count, line_count); end
      pw(2'd0, DT, 16'd4, 32'h301);
      short_pkt(2'd0, 6'h01);
      tick();
      checks++; if (flags4(0) !== 4'b0011 || flags4(1) !== 4'b0011) begin errors++; $display("FAIL b2b_marks: got sof=%b eol=%b want 0011/0011", flags4(0), flags4(1)); end
      checks++; if (frame_count !== 8'd2 || done_cnt != 1 || {err_line_length, err_line_count} !== 2'b00) begin errors++; $display("FAIL b2b_end: got fc=%0d done=%0d errs=%b want 2/1/00", frame_count, done_cnt, {err_line_length, err_line_count}); end
      clear_cap();
      do_arm(1'b0, 8'd0, 12'd1);
      short_pkt(2'd0, 6'h00);
      pw(2'd0, DT, 16'd0, 32'h302);
      short_pkt(2'd0, 6'h01);
      tick();
      checks++; if (busy !== 1'b0 || done_cnt != 1 || line_count !== 12'd1) begin errors++; $display("FAIL zero_frames_req: got busy=%0b done=%0d lc=%0d want 0/1/1", busy, done_cnt, line_count); end
   endtask

   task automatic test_timeout();
      int n;
      clear_cap();
      do_arm(1'b0, 8'd1, 12'd1);
      n = 0;
      while (done !== 1'b1 && n < 2000) begin
         tick();
         n++;
      end
      checks++; if (n != 256) begin errors++; $display("FAIL timeout_cycles: got %0d want 256", n); end
      checks++; if (err_timeout !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL timeout_state: got err=%0b busy=%0b want 1/0", err_timeout, busy); end
   endtask

   task automatic test_reset_mid_line();
      do_arm(1'b0, 8'd1, 12'd2);
      short_pkt(2'd0, 6'h00);
      pw(2'd0, DT, 16'd8, 32'h400);
      reset = 1'b1;
      interrupt = 1'b1; image_data_enable = 1'b1; image_data_type = DT;
      word_count = 16'd8; image_data = 32'h401;
      tick();
      reset = 1'b0;
      interrupt = 1'b0; image_data_enable = 1'b0; image_data_type = 6'd0;
      word_count = 16'd0; image_data = 32'd0;
      checks++; if ({out_valid, busy, done} !== 3'b000 || out_data !== 32'd0) begin errors++; $display("FAIL rst_mid_outputs: got v/b/d=%b data=%h want 000/0", {out_valid, busy, done}, out_data); end
      checks++; if (line_count !== '0 || frame_count !== 8'd0) begin errors++; $display("FAIL rst_mid_counts: got %0d/%0d want 0/0", line_count, frame_count); end
      tick();
      clear_cap();
      do_arm(1'b0, 8'd1, 12'd2);
      short_pkt(2'd0, 6'h00);
      for (int i = 0; i < 4; i++) pw(2'd0, DT, 16'd8, 32'h500 + i);
      short_pkt(2'd0, 6'h01);
      tick();
      checks++; if (cap_data.size() != 4 || flags4(0) !== 4'b0001 || flags4(1) !== 4'b1010) begin errors++; $display("FAIL rst_recapture: got n=%0d sof=%b eol=%b want 4/0001/1010", cap_data.size(), flags4(0), flags4(1)); end
      checks++; if (line_count !== 12'd2 || done_cnt != 1 || {err_line_length, err_line_count, err_timeout} !== 3'b0) begin errors++; $display("FAIL rst_recapture_end: got lc=%0d done=%0d errs=%b want 2/1/000", line_count, done_cnt, {err_line_length, err_line_count, err_timeout}); end
   endtask

   initial begin
      test_reset();
      test_single_frame();
      test_frame_errors();
      test_filter();
      test_continuous_abort();
      test_back_to_back();
      test_timeout();
      test_reset_mid_line();
      tick();
      checks++; if (bad_idle != 0) begin errors++; $display("FAIL idle_outputs_zero: got %0d nonzero idle cycles want 0", bad_idle); end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
